// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR sample path.
// Defaults match the FIR coefficient count and ring geometry.
package fir_pkg;

  localparam int DEF_DEPTH    = 1024;
  localparam int DEF_NUM_TAPS = 1021;
  localparam int DEF_AW       = 10;
  localparam int SMPL_W       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    BURST = 2'd2
  } state_e;

endpackage

// File: rtl/fir_sample_queue_if.sv
// Sample-in / burst-out stream between the queue and the FIR banks.
// The master side produces samples; the slave side replays bursts.
interface fir_sample_queue_if;
  import fir_pkg::*;

  logic                     wrt_smpl;
  logic signed [SMPL_W-1:0] lft_smpl;
  logic signed [SMPL_W-1:0] rht_smpl;
  logic                     sequencing;
  logic signed [SMPL_W-1:0] lft_out;
  logic signed [SMPL_W-1:0] rht_out;
  logic                     overrun;

  modport master (
    output wrt_smpl, lft_smpl, rht_smpl,
    input  sequencing, lft_out, rht_out, overrun
  );

  modport slave (
    input  wrt_smpl, lft_smpl, rht_smpl,
    output sequencing, lft_out, rht_out, overrun
  );

endinterface

// File: rtl/dualport_ram_32.sv
// 32-bit simple dual-port RAM, one write and one registered read port.
// Word layout is {left, right}; contents are never reset.
module dualport_ram_32 #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fir_sample_queue.sv
// Stereo ring buffer that replays the newest NUM_TAPS pairs,
// oldest first, once per incoming sample when full.
module fir_sample_queue
  import fir_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int AW       = DEF_AW
) (
  input logic          clk,
  input logic          rst,
  fir_sample_queue_if.slave q
);

  localparam logic [AW-1:0] NT    = AW'(NUM_TAPS);
  localparam logic [AW-1:0] NT_M1 = AW'(NUM_TAPS - 1);

  state_e state_q, state_d;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] fill_q, fill_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ovr_q, ovr_d;

  logic [2*SMPL_W-1:0] out_q, out_d;
  logic [2*SMPL_W-1:0] rdata;
  logic                full_nxt;
  logic                seq;

  dualport_ram_32 #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (q.wrt_smpl),
    .waddr (wptr_q),
    .wdata ({q.lft_smpl, q.rht_smpl}),
    .raddr (rptr_q),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    ovr_d    = ovr_q;
    seq      = (state_q == BURST);
    out_d    = seq ? rdata : out_q;
    full_nxt = (fill_q == NT) || (fill_q == NT_M1);

    if (q.wrt_smpl) begin
      wptr_d = wptr_q + AW'(1);
      if (fill_q != NT) fill_d = fill_q + AW'(1);
      if (state_q != IDLE) ovr_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (q.wrt_smpl && full_nxt) begin
          state_d = PRIME;
          // oldest of the newest NUM_TAPS, counting this write
          rptr_d  = wptr_q + AW'(1) - NT;
        end
      end
      PRIME: begin
        state_d = BURST;
        rptr_d  = rptr_q + AW'(1);
        cnt_d   = '0;
      end
      BURST: begin
        rptr_d = rptr_q + AW'(1);
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == NT_M1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign q.sequencing = seq;
  assign q.lft_out    = seq ? rdata[2*SMPL_W-1:SMPL_W] : out_q[2*SMPL_W-1:SMPL_W];
  assign q.rht_out    = seq ? rdata[SMPL_W-1:0] : out_q[SMPL_W-1:0];
  assign q.overrun    = ovr_q;

endmodule

// File: tb/tb_fir_sample_queue.sv
// Directed bench: small 8/5 queue for corner cases, default
// 1024/1021 queue for long bursts with boundary sample values.
module tb_fir_sample_queue;
  import fir_pkg::*;

  localparam int SD = 8;
  localparam int SN = 5;
  localparam int SA = 3;
  localparam int BN = DEF_NUM_TAPS;
  localparam int BW = 1100;

  logic clk = 1'b0;
  logic rst_s;
  logic rst_b;

  always #5 clk = ~clk;

  fir_sample_queue_if bs();
  fir_sample_queue_if bb();

  fir_sample_queue #(
    .DEPTH    (SD),
    .NUM_TAPS (SN),
    .AW       (SA)
  ) u_small (
    .clk (clk),
    .rst (rst_s),
    .q   (bs)
  );

  fir_sample_queue u_big (
    .clk (clk),
    .rst (rst_b),
    .q   (bb)
  );

  int vecs = 0;
  int errs = 0;

  logic signed [15:0] sl[$];
  logic signed [15:0] sr[$];
  logic signed [15:0] bl[BW];
  logic signed [15:0] br[BW];

  task automatic s_write(input logic signed [15:0] l,
                         input logic signed [15:0] r);
    @(negedge clk);
    bs.wrt_smpl = 1'b1;
    bs.lft_smpl = l;
    bs.rht_smpl = r;
    sl.push_back(l);
    sr.push_back(r);
    @(negedge clk);
    bs.wrt_smpl = 1'b0;
  endtask

  task automatic s_no_burst(input string tag);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      vecs++;
      if (bs.sequencing !== 1'b0) begin
        errs++;
        $display("FAIL %s cyc%0d: sequencing=%b, want 0", tag, c, bs.sequencing);
      end
    end
  endtask

  // Entered at the negedge right after the triggering write edge.
  task automatic s_check_burst(input string tag, input int wr_k,
                               input logic signed [15:0] wl,
                               input logic signed [15:0] wr);
    int base;
    base = sl.size() - SN;
    vecs++;
    if (bs.sequencing !== 1'b0) begin
      errs++;
      $display("FAIL %s prime: sequencing=%b, want 0", tag, bs.sequencing);
    end
    for (int k = 0; k < SN; k++) begin
      @(negedge clk);
      bs.wrt_smpl = 1'b0;
      vecs++;
      if (bs.sequencing !== 1'b1 || bs.lft_out !== sl[base+k] ||
          bs.rht_out !== sr[base+k]) begin
        errs++;
        $display("FAIL %s beat%0d: seq=%b L=%0d R=%0d, want seq=1 L=%0d R=%0d",
                 tag, k, bs.sequencing, bs.lft_out, bs.rht_out,
                 sl[base+k], sr[base+k]);
      end
      if (k == wr_k) begin
        bs.wrt_smpl = 1'b1;
        bs.lft_smpl = wl;
        bs.rht_smpl = wr;
      end
    end
    @(negedge clk);
    bs.wrt_smpl = 1'b0;
    vecs++;
    if (bs.sequencing !== 1'b0 || bs.lft_out !== sl[base+SN-1] ||
        bs.rht_out !== sr[base+SN-1]) begin
      errs++;
      $display("FAIL %s end: seq=%b L=%0d R=%0d, want seq=0 L=%0d R=%0d",
               tag, bs.sequencing, bs.lft_out, bs.rht_out,
               sl[base+SN-1], sr[base+SN-1]);
    end
    if (wr_k >= 0) begin
      sl.push_back(wl);
      sr.push_back(wr);
    end
  endtask

  task automatic b_write(input int i);
    @(negedge clk);
    bb.wrt_smpl = 1'b1;
    bb.lft_smpl = bl[i];
    bb.rht_smpl = br[i];
    @(negedge clk);
    bb.wrt_smpl = 1'b0;
  endtask

  task automatic b_burst(input string tag, input int newest,
                         input int wr_from, input int wr_cnt);
    int base;
    base = newest - BN + 1;
    vecs++;
    if (bb.sequencing !== 1'b0) begin
      errs++;
      $display("FAIL %s prime: sequencing=%b, want 0", tag, bb.sequencing);
    end
    for (int k = 0; k < BN; k++) begin
      @(negedge clk);
      bb.wrt_smpl = 1'b0;
      vecs++;
      if (bb.sequencing !== 1'b1 || bb.lft_out !== bl[base+k] ||
          bb.rht_out !== br[base+k]) begin
        errs++;
        $display("FAIL %s beat%0d: seq=%b L=%h R=%h, want seq=1 L=%h R=%h",
                 tag, k, bb.sequencing, bb.lft_out, bb.rht_out,
                 bl[base+k], br[base+k]);
      end
      if (k < wr_cnt) begin
        bb.wrt_smpl = 1'b1;
        bb.lft_smpl = bl[wr_from+k];
        bb.rht_smpl = br[wr_from+k];
      end
    end
    @(negedge clk);
    bb.wrt_smpl = 1'b0;
    vecs++;
    if (bb.sequencing !== 1'b0 || bb.lft_out !== bl[newest] ||
        bb.rht_out !== br[newest]) begin
      errs++;
      $display("FAIL %s end: seq=%b L=%h R=%h, want seq=0 L=%h R=%h",
               tag, bb.sequencing, bb.lft_out, bb.rht_out,
               bl[newest], br[newest]);
    end
  endtask

  task automatic test_reset();
    rst_s = 1'b1;
    rst_b = 1'b1;
    bs.wrt_smpl = 1'b0;
    bs.lft_smpl = '0;
    bs.rht_smpl = '0;
    bb.wrt_smpl = 1'b0;
    bb.lft_smpl = '0;
    bb.rht_smpl = '0;
    @(negedge clk);
    @(negedge clk);
    vecs++;
    if ({bs.sequencing, bs.overrun, bs.lft_out, bs.rht_out} !== 34'd0) begin
      errs++;
      $display("FAIL reset_small: seq=%b ovr=%b L=%0d R=%0d, want all 0",
               bs.sequencing, bs.overrun, bs.lft_out, bs.rht_out);
    end
    vecs++;
    if ({bb.sequencing, bb.overrun, bb.lft_out, bb.rht_out} !== 34'd0) begin
      errs++;
      $display("FAIL reset_big: seq=%b ovr=%b L=%0d R=%0d, want all 0",
               bb.sequencing, bb.overrun, bb.lft_out, bb.rht_out);
    end
    rst_s = 1'b0;
    rst_b = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      s_write(16'(i), -16'(i));
      s_no_burst($sformatf("fill%0d", i));
    end
    vecs++;
    if (bs.overrun !== 1'b0) begin
      errs++;
      $display("FAIL fill_ovr: overrun=%b, want 0", bs.overrun);
    end
  endtask

  task automatic test_first_burst();
    s_write(16'sd5, -16'sd5);
    s_check_burst("first", -1, '0, '0);
  endtask

  task automatic test_sliding();
    for (int i = 6; i <= 10; i++) begin
      s_write(16'(i), -16'(i));
      s_check_burst($sformatf("slide%0d", i), -1, '0, '0);
    end
  endtask

  task automatic test_overrun();
    s_write(16'sd11, -16'sd11);
    s_check_burst("wrap11", 1, 16'sd12, -16'sd12);
    vecs++;
    if (bs.overrun !== 1'b1) begin
      errs++;
      $display("FAIL ovr_set: overrun=%b, want 1", bs.overrun);
    end
    @(negedge clk);
    s_no_burst("no_queued");
    s_write(16'sd13, -16'sd13);
    s_check_burst("after13", -1, '0, '0);
    vecs++;
    if (bs.overrun !== 1'b1) begin
      errs++;
      $display("FAIL ovr_sticky: overrun=%b, want 1", bs.overrun);
    end
  endtask

  task automatic test_reset_mid_burst();
    s_write(16'sd14, -16'sd14);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    vecs++;
    if (bs.sequencing !== 1'b1 || bs.lft_out !== 16'sd12) begin
      errs++;
      $display("FAIL pre_rst: seq=%b L=%0d, want seq=1 L=12",
               bs.sequencing, bs.lft_out);
    end
    #1 rst_s = 1'b1;
    #1;
    vecs++;
    if ({bs.sequencing, bs.overrun, bs.lft_out, bs.rht_out} !== 34'd0) begin
      errs++;
      $display("FAIL mid_rst: seq=%b ovr=%b L=%0d R=%0d, want all 0",
               bs.sequencing, bs.overrun, bs.lft_out, bs.rht_out);
    end
    @(negedge clk);
    rst_s = 1'b0;
    sl.delete();
    sr.delete();
    for (int i = 0; i < 4; i++) begin
      s_write(16'(100 + i), -16'(100 + i));
      s_no_burst($sformatf("refill%0d", i));
    end
    s_write(16'sd104, -16'sd104);
    s_check_burst("refilled", -1, '0, '0);
  endtask

  task automatic test_big();
    for (int i = 0; i < BW; i++) begin
      bl[i] = 16'($urandom);
      br[i] = 16'($urandom);
    end
    bl[500]  = 16'h7FFF;
    br[500]  = 16'h8000;
    bl[1090] = 16'h7FFF;
    br[1090] = 16'h8000;
    bl[1091] = 16'h8000;
    br[1091] = 16'h7FFF;
    for (int i = 0; i < BN - 1; i++) b_write(i);
    vecs++;
    if (bb.sequencing !== 1'b0) begin
      errs++;
      $display("FAIL big_fill: sequencing=%b, want 0", bb.sequencing);
    end
    b_write(BN - 1);
    b_burst("bigA", BN - 1, BN, 40);
    b_write(1061);
    b_burst("bigB", 1061, 1062, 37);
    b_write(1099);
    b_burst("bigC", 1099, 0, 0);
    vecs++;
    if (bb.overrun !== 1'b1) begin
      errs++;
      $display("FAIL big_ovr: overrun=%b, want 1", bb.overrun);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_first_burst();
    test_sliding();
    test_overrun();
    test_reset_mid_burst();
    test_big();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fir_sample_queue.md
Name: fir_sample_queue

Overview:
- Stereo circular sample buffer that feeds the FIR filter banks.
- Stores each incoming left/right sample pair into a ring.
- Once at least NUM_TAPS samples are held, every new sample triggers a burst: the most recent NUM_TAPS pairs are replayed oldest-first, one pair per clock, with `sequencing` high for exactly NUM_TAPS cycles.
- This is the producer side of the `sequencing` / `lft_in` / `rht_in` stream consumed by the FIR blocks.

Parameters:
- DEPTH, 1024: ring depth in sample pairs; must be a power of two.
- NUM_TAPS, 1021: pairs replayed per burst; equals the FIR coefficient count (0x3FD); must satisfy NUM_TAPS <= DEPTH-2.
- AW, 10: address width, log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- wrt_smpl  in  1  single-cycle strobe; a new pair is present on lft_smpl/rht_smpl.
- lft_smpl  in  16  signed left sample.
- rht_smpl  in  16  signed right sample.
- sequencing  out  1  high while the burst pairs are valid on lft_out/rht_out.
- lft_out  out  16  signed left sample of the current burst position.
- rht_out  out  16  signed right sample of the current burst position.
- overrun  out  1  sticky flag: wrt_smpl arrived during a burst.

Behaviour:
- Reset (async, rst=1), all clear to 0: write pointer, read pointer, fill counter, burst counter, state, sequencing, lft_out, rht_out, overrun. RAM contents are not cleared.
- Write path:
  - On wrt_smpl, {lft_smpl, rht_smpl} is written at wptr, then wptr increments modulo DEPTH (natural AW-bit wrap).
  - Writes always occur, including during a burst.
- Fill counter:
  - Counts written samples and saturates at NUM_TAPS; `full` = (fill == NUM_TAPS).
  - Bursts are never started while not full.
- FSM states IDLE, PRIME, BURST:
  - IDLE -> PRIME: on wrt_smpl when the write makes the buffer full (i.e. fill==NUM_TAPS-1 and wrt_smpl, or already full). Latch rptr = wptr_after_write - NUM_TAPS (mod DEPTH), i.e. the oldest of the last NUM_TAPS pairs, including the one just written.
  - PRIME -> BURST: unconditional, one cycle. Issues the first synchronous RAM read.
  - BURST: sequencing=1. Each cycle present one pair, advance rptr (mod DEPTH), increment the burst counter.
  - BURST -> IDLE: after NUM_TAPS cycles. Sequencing drops the cycle after the newest pair is shown.
- Latency: wrt_smpl at cycle T -> sequencing high at T+2 (through T+1+NUM_TAPS).
  - First output pair is the oldest sample.
  - The last output pair is the sample written at T.
- Burst output is contiguous: no gaps and no stalls.
- Between bursts, lft_out/rht_out hold the last replayed pair.
- wrt_smpl during PRIME/BURST:
  - The sample is written.
  - The running burst continues unchanged, and no new burst is queued.
  - overrun is set; it clears only on rst.
  - The burst reads are unaffected because only slots that are at least 2 positions ahead of the oldest are overwritten (DEPTH - NUM_TAPS >= 2).
- Pointer wrap: rptr and wptr wrap DEPTH-1 -> 0 with no discontinuity in the output order.
- rst asserted mid-burst: sequencing drops immediately (async); the FSM returns to IDLE and a full refill of NUM_TAPS samples is required before the next burst.

Decomposition:
- Shared package fir_pkg holds:
  - DEPTH, NUM_TAPS, AW defaults.
  - State encoding IDLE/PRIME/BURST.
  - Sample width (16) constant, shared with the FIR blocks.
- One sub-module, dualport_ram_32: 32-bit x DEPTH, one write port, one read port, synchronous read (1-cycle latency); word = {left, right}.
- The queue wraps it with pointers, counters and the FSM.

Test Plan:
- Bench parameters: DEPTH=8, NUM_TAPS=5. Write 4 pairs (L=1..4, R=-1..-4) -> sequencing stays 0, overrun 0.
- Write the 5th pair (5,-5) at cycle T -> sequencing high at T+2..T+6 exactly. Outputs L=1,2,3,4,5 and R=-1..-5 in order. Outputs hold (5,-5) afterwards.
- Write 6 more pairs (6..11), each after the prior burst completes -> each burst is the last 5 written. The burst after writing 11 outputs 7,8,9,10,11, spanning the wptr wrap 7->0.
- wrt_smpl of 12 during the burst triggered by 11 -> burst still outputs 7..11, no second burst starts, and overrun=1. The next wrt_smpl (13) yields the burst 9,10,11,12,13.
- Assert rst during the 3rd burst cycle -> sequencing=0 and outputs=0 in the same cycle. Then 4 writes give no burst, and the 5th write gives a burst of those 5 values only.
- Default parameters, random 16-bit samples across 1100 writes -> every burst is 1021 cycles long and matches the last 1021 written samples of a reference model, including boundary values 0x7FFF and 0x8000.
